// File: rtl/ate_stream.sv
// Block adaptive-threshold binariser with ping-pong block banks and valid/ready
// handshakes. Each block's threshold is ceil((max+min)/2); edge blocks can be blanked.
module ate_stream #(
   parameter int PIX_W        = 8,
   parameter int BLK_LOG2     = 6,
   parameter int BLKS_PER_ROW = 6,
   parameter int BLK_ROWS     = 4,
   parameter int BORDER_MODE  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             in_sof,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             bin,
   output logic [PIX_W-1:0] threshold,
   output logic             out_last,
   output logic             out_border
);
   // state | meaning
   // IDLE  | no full bank to drain; out_valid low, threshold holds last value
   // DRAIN | presenting pixels of bank rd_bank_q, one per output transfer
   typedef enum logic {IDLE, DRAIN} state_t;

   localparam int N  = 1 << BLK_LOG2;
   localparam int CW = (BLKS_PER_ROW > 1) ? $clog2(BLKS_PER_ROW) : 1;
   localparam int RW = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;

   logic [PIX_W-1:0]    mem [2][N];

   state_t              state_q, state_d;
   logic                wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [1:0]          full_q, full_d;
   logic [BLK_LOG2-1:0] pix_cnt_q, pix_cnt_d, rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]       blk_col_q, blk_col_d;
   logic [RW-1:0]       blk_row_q, blk_row_d;
   logic [PIX_W-1:0]    max_q, max_d, min_q, min_d;
   logic [PIX_W-1:0]    thr_q [2];
   logic [PIX_W-1:0]    thr_d [2];
   logic                brd_q [2];
   logic                brd_d [2];
   logic                out_valid_q, out_valid_d, bin_q, bin_d;
   logic                out_last_q, out_last_d, out_border_q, out_border_d;
   logic [PIX_W-1:0]    threshold_q, threshold_d;

   logic                accept, last_px, brd_new, free, load_en, load_bank, other_bank;
   logic [BLK_LOG2-1:0] eff_cnt, load_idx;
   logic [CW-1:0]       eff_col;
   logic [RW-1:0]       eff_row;
   logic [PIX_W-1:0]    mx_new, mn_new, thr_new, load_px, load_thr;
   logic [PIX_W:0]      sum, sum_p1;
   logic                load_brd;

   assign in_ready   = !full_q[wr_bank_q];
   assign out_valid  = out_valid_q;
   assign bin        = bin_q;
   assign threshold  = threshold_q;
   assign out_last   = out_last_q;
   assign out_border = out_border_q;

   // Capture side: an accepted in_sof restarts the frame at pixel 0 of block (0,0).
   always_comb begin
      accept  = in_valid && in_ready;
      eff_cnt = in_sof ? '0 : pix_cnt_q;
      eff_col = in_sof ? '0 : blk_col_q;
      eff_row = in_sof ? '0 : blk_row_q;
      mx_new  = (eff_cnt == '0 || pix_data > max_q) ? pix_data : max_q;
      mn_new  = (eff_cnt == '0 || pix_data < min_q) ? pix_data : min_q;
      sum     = {1'b0, mx_new} + {1'b0, mn_new};
      sum_p1  = sum + 1'b1;
      thr_new = sum_p1[PIX_W:1];
      last_px = accept && (&eff_cnt);

      brd_new = 1'b0;
      if (BORDER_MODE >= 1)
         brd_new = (eff_col == '0) || (eff_col == CW'(BLKS_PER_ROW - 1));
      if (BORDER_MODE == 2)
         brd_new = brd_new || (eff_row == '0) || (eff_row == RW'(BLK_ROWS - 1));

      pix_cnt_d = pix_cnt_q;
      blk_col_d = blk_col_q;
      blk_row_d = blk_row_q;
      max_d     = max_q;
      min_d     = min_q;
      wr_bank_d = wr_bank_q ^ last_px;
      thr_d     = thr_q;
      brd_d     = brd_q;
      if (accept) begin
         pix_cnt_d = eff_cnt + 1'b1;
         max_d     = mx_new;
         min_d     = mn_new;
         blk_col_d = eff_col;
         blk_row_d = eff_row;
      end
      if (last_px) begin
         thr_d[wr_bank_q] = thr_new;
         brd_d[wr_bank_q] = brd_new;
         if (eff_col == CW'(BLKS_PER_ROW - 1)) begin
            blk_col_d = '0;
            blk_row_d = (eff_row == RW'(BLK_ROWS - 1)) ? '0 : eff_row + 1'b1;
         end else begin
            blk_col_d = eff_col + 1'b1;
         end
      end
   end

   // Drain side: outputs are registered and loaded one pixel ahead of the transfer.
   always_comb begin
      state_d      = state_q;
      rd_bank_d    = rd_bank_q;
      rd_cnt_d     = rd_cnt_q;
      out_valid_d  = out_valid_q;
      bin_d        = bin_q;
      threshold_d  = threshold_q;
      out_last_d   = out_last_q;
      out_border_d = out_border_q;
      free         = 1'b0;
      load_en      = 1'b0;
      load_bank    = rd_bank_q;
      load_idx     = '0;
      other_bank   = ~rd_bank_q;

      case (state_q)
         IDLE: begin
            if (full_q[rd_bank_q]) begin
               load_en = 1'b1;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (&rd_cnt_q) begin
                  free      = 1'b1;
                  rd_bank_d = other_bank;
                  if (full_q[other_bank]) begin
                     load_en   = 1'b1;
                     load_bank = other_bank;
                  end else begin
                     state_d      = IDLE;
                     out_valid_d  = 1'b0;
                     bin_d        = 1'b0;
                     out_last_d   = 1'b0;
                     out_border_d = 1'b0;
                  end
               end else begin
                  load_en  = 1'b1;
                  load_idx = rd_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      load_px  = mem[load_bank][load_idx];
      load_thr = thr_q[load_bank];
      load_brd = brd_q[load_bank];
      if (load_en) begin
         rd_cnt_d     = load_idx;
         out_valid_d  = 1'b1;
         bin_d        = !load_brd && (load_px >= load_thr);
         threshold_d  = load_brd ? '0 : load_thr;
         out_last_d   = &load_idx;
         out_border_d = load_brd;
      end

      full_d = full_q;
      if (free)
         full_d[rd_bank_q] = 1'b0;
      if (last_px)
         full_d[wr_bank_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_bank_q][eff_cnt] <= pix_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         full_q       <= '0;
         pix_cnt_q    <= '0;
         rd_cnt_q     <= '0;
         blk_col_q    <= '0;
         blk_row_q    <= '0;
         max_q        <= '0;
         min_q        <= '0;
         thr_q        <= '{default: '0};
         brd_q        <= '{default: 1'b0};
         out_valid_q  <= 1'b0;
         bin_q        <= 1'b0;
         threshold_q  <= '0;
         out_last_q   <= 1'b0;
         out_border_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         full_q       <= full_d;
         pix_cnt_q    <= pix_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         blk_col_q    <= blk_col_d;
         blk_row_q    <= blk_row_d;
         max_q        <= max_d;
         min_q        <= min_d;
         thr_q        <= thr_d;
         brd_q        <= brd_d;
         out_valid_q  <= out_valid_d;
         bin_q        <= bin_d;
         threshold_q  <= threshold_d;
         out_last_q   <= out_last_d;
         out_border_q <= out_border_d;
      end
   end
endmodule

// File: tb/tb_ate_stream.sv
// Directed bench for ate_stream: three instances (border modes 0, 1, 2) driven in
// lockstep, each output beat compared against thresholds computed from the block data.
module tb_ate_stream;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_sof = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] pix_data = '0;

   logic       ir [3];
   logic       ov [3];
   logic       bn [3];
   logic       ol [3];
   logic       ob [3];
   logic [7:0] th [3];

   int checks = 0;
   int failures = 0;

   logic [7:0] cur [64];
   logic [7:0] rcv [64];
   logic [7:0] blk_a [64];
   logic [7:0] blk_b [64];
   int wcol = 0, wrow = 0, scol = 0, srow = 0, rcol = 0, rrow = 0;
   int pa_col, pa_row, pb_col, pb_row;

   always #5 clk = ~clk;

   ate_stream #(.BORDER_MODE(0)) dut0 (.clk(clk), .reset(reset), .in_valid(in_valid),
      .in_ready(ir[0]), .pix_data(pix_data), .in_sof(in_sof), .out_valid(ov[0]),
      .out_ready(out_ready), .bin(bn[0]), .threshold(th[0]), .out_last(ol[0]),
      .out_border(ob[0]));
   ate_stream #(.BORDER_MODE(1)) dut1 (.clk(clk), .reset(reset), .in_valid(in_valid),
      .in_ready(ir[1]), .pix_data(pix_data), .in_sof(in_sof), .out_valid(ov[1]),
      .out_ready(out_ready), .bin(bn[1]), .threshold(th[1]), .out_last(ol[1]),
      .out_border(ob[1]));
   ate_stream #(.BORDER_MODE(2)) dut2 (.clk(clk), .reset(reset), .in_valid(in_valid),
      .in_ready(ir[2]), .pix_data(pix_data), .in_sof(in_sof), .out_valid(ov[2]),
      .out_ready(out_ready), .bin(bn[2]), .threshold(th[2]), .out_last(ol[2]),
      .out_border(ob[2]));

   task automatic chk(input string tag, input int m, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s[mode%0d] observed=%0d expected=%0d", tag, m, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int border_of(input int m, input int c, input int r);
      int b = 0;
      if (m >= 1 && (c == 0 || c == 5)) b = 1;
      if (m == 2 && (r == 0 || r == 3)) b = 1;
      return b;
   endfunction

   function automatic int rcv_thr();
      int mx = 0, mn = 255;
      for (int i = 0; i < 64; i++) begin
         if (int'(rcv[i]) > mx) mx = int'(rcv[i]);
         if (int'(rcv[i]) < mn) mn = int'(rcv[i]);
      end
      return (mx + mn + 1) / 2;
   endfunction

   task automatic send(input bit sof);
      if (sof) begin
         wcol = 0;
         wrow = 0;
      end
      scol = wcol;
      srow = wrow;
      for (int i = 0; i < 64; i++) begin
         in_valid = 1'b1;
         pix_data = cur[i];
         in_sof   = sof && (i == 0);
         chk("in_ready", 0, int'(ir[0]), 1);
         step();
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      wcol++;
      if (wcol == 6) begin
         wcol = 0;
         wrow = (wrow + 1) % 4;
      end
   endtask

   // Checks nb beats of block rcv at (rcol,rrow) with out_ready held high.
   task automatic recv(input int nb);
      int t = rcv_thr();
      for (int j = 0; j < nb; j++) begin
         for (int m = 0; m < 3; m++) begin
            int b = border_of(m, rcol, rrow);
            chk("out_valid", m, int'(ov[m]), 1);
            chk("bin", m, int'(bn[m]), (b == 1) ? 0 : int'(int'(rcv[j]) >= t));
            chk("threshold", m, int'(th[m]), (b == 1) ? 0 : t);
            chk("out_last", m, int'(ol[m]), int'(j == 63));
            chk("out_border", m, int'(ob[m]), b);
         end
         step();
      end
   endtask

   task automatic block_roundtrip();
      send(1'b0);
      rcv = cur;
      rcol = scol;
      rrow = srow;
      chk("latency_pre", 0, int'(ov[0]), 0);
      step();
      chk("latency_first", 0, int'(ov[0]), 1);
   endtask

   initial begin
      // Reset state
      #1;
      for (int m = 0; m < 3; m++) begin
         chk("rst_in_ready", m, int'(ir[m]), 1);
         chk("rst_out_valid", m, int'(ov[m]), 0);
         chk("rst_bin", m, int'(bn[m]), 0);
         chk("rst_threshold", m, int'(th[m]), 0);
         chk("rst_out_last", m, int'(ol[m]), 0);
         chk("rst_out_border", m, int'(ob[m]), 0);
      end
      step();
      step();
      reset = 1'b0;
      step();

      // Row 0: random, ramp, zeros, 255/0, random, random (cols 0..5)
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 64; i++) begin
            case (k)
               1:       cur[i] = 8'(10 + i);
               2:       cur[i] = 8'd0;
               3:       cur[i] = (i == 5) ? 8'd255 : ((i == 40) ? 8'd0 : 8'd77);
               default: cur[i] = 8'($urandom_range(0, 255));
            endcase
         end
         block_roundtrip();
         if (k == 1) begin
            chk("ramp_thr", 0, int'(th[0]), 42);
            chk("ramp_thr", 1, int'(th[1]), 42);
            chk("ramp_row0_blank", 2, int'(th[2]), 0);
         end
         if (k == 2) begin
            chk("zero_thr", 0, int'(th[0]), 0);
            chk("zero_bin", 0, int'(bn[0]), 1);
         end
         if (k == 3) chk("wide_sum_thr", 0, int'(th[0]), 128);
         if (k == 0 || k == 5) chk("edge_col_border", 1, int'(ob[1]), 1);
         recv(64);
         chk("drained_idle", 0, int'(ov[0]), 0);
      end

      // Backpressure: out_ready low, two blocks fill both banks, third stalls
      out_ready = 1'b0;
      for (int i = 0; i < 64; i++) cur[i] = 8'($urandom_range(0, 255));
      blk_a = cur;
      send(1'b0);
      pa_col = scol;
      pa_row = srow;
      chk("bp_ready_after_64", 0, int'(ir[0]), 1);
      for (int i = 0; i < 64; i++) cur[i] = 8'($urandom_range(0, 255));
      blk_b = cur;
      send(1'b0);
      pb_col = scol;
      pb_row = srow;
      for (int i = 0; i < 64; i++) cur[i] = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      pix_data = cur[0];
      rcv = blk_a;
      for (int c = 0; c < 10; c++) begin
         chk("bp_in_ready_low", 0, int'(ir[0]), 0);
         chk("bp_hold_valid", 0, int'(ov[0]), 1);
         chk("bp_hold_thr", 0, int'(th[0]), rcv_thr());
         chk("bp_hold_bin", 0, int'(bn[0]), int'(int'(blk_a[0]) >= rcv_thr()));
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      rcol = pa_col;
      rrow = pa_row;
      recv(64);
      chk("bp_ready_after_drain", 0, int'(ir[0]), 1);
      rcv = blk_b;
      rcol = pb_col;
      rrow = pb_row;
      recv(64);
      chk("bp_idle_after_b", 0, int'(ov[0]), 0);
      block_roundtrip();
      recv(64);

      // in_sof mid-block: 20 pixels of 0/255 are discarded
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         pix_data = (i % 2 == 0) ? 8'd255 : 8'd0;
         step();
      end
      for (int i = 0; i < 64; i++) cur[i] = 8'(100 + i);
      send(1'b1);
      rcv = cur;
      rcol = scol;
      rrow = srow;
      step();
      chk("sof_thr", 0, int'(th[0]), 132);
      chk("sof_col0_border", 1, int'(ob[1]), 1);
      recv(64);

      // Reset at output beat 30
      for (int i = 0; i < 64; i++) cur[i] = 8'($urandom_range(0, 255));
      block_roundtrip();
      recv(30);
      reset = 1'b1;
      #1;
      for (int m = 0; m < 3; m++) begin
         chk("rst_mid_out_valid", m, int'(ov[m]), 0);
         chk("rst_mid_bin", m, int'(bn[m]), 0);
         chk("rst_mid_threshold", m, int'(th[m]), 0);
         chk("rst_mid_in_ready", m, int'(ir[m]), 1);
      end
      step();
      reset = 1'b0;
      wcol = 0;
      wrow = 0;
      step();
      for (int i = 0; i < 64; i++) cur[i] = 8'($urandom_range(0, 255));
      block_roundtrip();
      recv(64);
      chk("final_idle", 0, int'(ov[0]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
